// File: rtl/temp_code_sweeper.sv
// Sweeps an 8-bit switch code across [lo, hi], holding each code for HOLD_CYCLES
// cycles and sampling the window detector's LED response at the end of each hold.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results from the previous sweep are held
// S_DRIVE | code_out valid; hold counter runs, led_in sampled at its end
// S_FIN   | one-cycle done pulse, then back to S_IDLE
module temp_code_sweeper #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_code_lo,
  input  logic [7:0] i_code_hi,
  input  logic       i_led_in,
  output logic [7:0] o_code_out,
  output logic       o_code_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic [8:0] o_hit_count,
  output logic [7:0] o_first_hit,
  output logic [7:0] o_last_hit,
  output logic       o_any_hit
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_hi;
  logic [7:0] r_code;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;
  logic [8:0] r_hit_count;
  logic [7:0] r_first_hit;
  logic [7:0] r_last_hit;
  logic       r_any_hit;

  logic w_sample;
  logic w_hit;
  logic w_last_code;

  assign w_sample    = (r_hold_cnt == HOLD_LAST);
  assign w_hit       = w_sample && i_led_in;
  // End-of-sweep test uses the current code before any increment, so hi=255 never wraps.
  assign w_last_code = (r_code == r_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= 8'd0;
      r_hi        <= 8'd0;
      r_code      <= 8'd0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit_count <= 9'd0;
      r_first_hit <= 8'd0;
      r_last_hit  <= 8'd0;
      r_any_hit   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_hi        <= i_code_hi;
            r_hold_cnt  <= 8'd0;
            r_hit_count <= 9'd0;
            r_first_hit <= 8'd0;
            r_last_hit  <= 8'd0;
            r_any_hit   <= 1'b0;
            if (i_code_lo <= i_code_hi) begin
              r_state <= S_DRIVE;
              r_code  <= i_code_lo;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end

        S_DRIVE: begin
          if (w_sample) begin
            r_hold_cnt <= 8'd0;
            if (w_hit) begin
              r_hit_count <= r_hit_count + 9'd1;
              r_last_hit  <= r_code;
              if (!r_any_hit) begin
                r_first_hit <= r_code;
                r_any_hit   <= 1'b1;
              end
            end
            if (w_last_code) begin
              r_state <= S_FIN;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_code <= r_code + 8'd1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_code_out   = r_code;
  assign o_code_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_hit_count  = r_hit_count;
  assign o_first_hit  = r_first_hit;
  assign o_last_hit   = r_last_hit;
  assign o_any_hit    = r_any_hit;

endmodule

// File: tb/tb_temp_code_sweeper.sv
// Bench for temp_code_sweeper: timeline-based reference model compared every cycle,
// plus directed sweeps with hand-computed result literals.
module tb_temp_code_sweeper;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] code_lo = 8'd0;
  logic [7:0] code_hi = 8'd0;
  logic       led_in = 1'b0;
  logic [7:0] code_out;
  logic       code_valid;
  logic       busy;
  logic       done;
  logic [8:0] hit_count;
  logic [7:0] first_hit;
  logic [7:0] last_hit;
  logic       any_hit;

  temp_code_sweeper #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_code_lo(code_lo), .i_code_hi(code_hi),
    .i_led_in(led_in), .o_code_out(code_out), .o_code_valid(code_valid), .o_busy(busy),
    .o_done(done), .o_hit_count(hit_count), .o_first_hit(first_hit), .o_last_hit(last_hit),
    .o_any_hit(any_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mode = 3;      // 0: window detector 128..154, 1: always high, 2: high off-sample only, 3: low
  bit cmp_en = 1'b0;
  int valid_cnt = 0;
  int done_cnt = 0;

  // Reference model: position in the sweep is derived from edges elapsed since start.
  logic [7:0] e_code = 0, e_first = 0, e_last = 0;
  logic       e_valid = 0, e_busy = 0, e_done = 0, e_any = 0;
  int         e_hits = 0;
  bit         m_run = 0;
  int         m_k = 0, m_n = 0, m_lo = 0, m_code = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_code = 0; e_first = 0; e_last = 0; e_valid = 0; e_busy = 0; e_done = 0; e_any = 0;
      e_hits = 0; m_run = 0; m_k = 0;
    end else if (m_run) begin
      e_done = 0;
      m_k++;
      if (m_k % H == 0) begin
        m_code = m_lo + m_k / H - 1;
        if (led_in) begin
          e_hits++;
          e_last = 8'(m_code);
          if (!e_any) begin e_first = 8'(m_code); e_any = 1; end
        end
        if (m_k == m_n * H) begin
          m_run = 0; e_valid = 0; e_busy = 0; e_done = 1;
        end else begin
          e_code = 8'(m_code + 1);
        end
      end
    end else if (e_done) begin
      e_done = 0;
    end else if (start) begin
      e_hits = 0; e_first = 0; e_last = 0; e_any = 0;
      if (code_lo <= code_hi) begin
        m_run = 1; m_k = 0; m_lo = int'(code_lo); m_n = int'(code_hi) - int'(code_lo) + 1;
        e_code = code_lo; e_valid = 1; e_busy = 1;
      end else begin
        e_done = 1;
      end
    end
  end

  // Detector stand-in, updated away from the sampling edge.
  always @(negedge clk) begin
    case (mode)
      0: led_in = (code_out >= 8'd128) && (code_out <= 8'd154);
      1: led_in = 1'b1;
      2: led_in = m_run && (((m_k + 1) % H) != 0);
      default: led_in = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (code_valid) valid_cnt++;
    if (done) done_cnt++;
    if (rst_n && cmp_en) begin
      checks++;
      if ({code_out, code_valid, busy, done, hit_count, first_hit, last_hit, any_hit} !==
          {e_code, e_valid, e_busy, e_done, 9'(e_hits), e_first, e_last, e_any}) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got code=%0d v=%0b b=%0b d=%0b hits=%0d first=%0d last=%0d any=%0b exp code=%0d v=%0b b=%0b d=%0b hits=%0d first=%0d last=%0d any=%0b",
                 $time, code_out, code_valid, busy, done, hit_count, first_hit, last_hit, any_hit,
                 e_code, e_valid, e_busy, e_done, e_hits, e_first, e_last, e_any);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Runs one sweep; optionally pokes start mid-sweep (poke_at>0) and in the done cycle.
  task automatic run(input int lo, input int hi, input int m, input int poke_at,
                     input bit fin_poke, output int lat);
    @(negedge clk);
    mode = m;
    code_lo = 8'(lo); code_hi = 8'(hi);
    valid_cnt = 0; done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      if (poke_at > 0 && lat == poke_at) begin
        code_lo = 8'd10; code_hi = 8'd20; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", lat, -1);
    if (fin_poke) begin
      code_lo = 8'd10; code_hi = 8'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("fin_poke_busy", int'(busy), 0);
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
  endtask

  int lat;
  int guard;
  int done_snap;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", int'(code_out), 0);
    chk("rst_valid_busy_done", int'({code_valid, busy, done}), 0);
    chk("rst_results", int'({hit_count, first_hit, last_hit, any_hit}), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: window sweep 120..160
    run(120, 160, 0, 0, 0, lat);
    chk("t1_valid_cycles", valid_cnt, 164);
    chk("t1_latency", lat, 165);
    chk("t1_hits", int'(hit_count), 27);
    chk("t1_model_hits", e_hits, 27);
    chk("t1_first", int'(first_hit), 128);
    chk("t1_last", int'(last_hit), 154);
    chk("t1_any", int'(any_hit), 1);

    // 2: full range, no wrap
    run(0, 255, 0, 0, 0, lat);
    chk("t2_valid_cycles", valid_cnt, 1024);
    chk("t2_hits", int'(hit_count), 27);
    chk("t2_final_code", int'(code_out), 255);

    // 3: single code, then full range all hits
    run(130, 130, 1, 0, 0, lat);
    chk("t3_valid_cycles", valid_cnt, 4);
    chk("t3_hits", int'(hit_count), 1);
    chk("t3_first", int'(first_hit), 130);
    chk("t3_last", int'(last_hit), 130);
    run(0, 255, 1, 0, 0, lat);
    chk("t3_full_hits", int'(hit_count), 256);
    chk("t3_full_first", int'(first_hit), 0);
    chk("t3_full_last", int'(last_hit), 255);

    // 4: inverted bounds
    run(200, 100, 0, 0, 0, lat);
    chk("t4_latency", lat, 1);
    chk("t4_valid_cycles", valid_cnt, 0);
    chk("t4_hits", int'(hit_count), 0);
    chk("t4_any", int'(any_hit), 0);

    // 5: start ignored while busy and during done; off-sample led pulses ignored
    run(140, 150, 0, 10, 1, lat);
    chk("t5_hits", int'(hit_count), 11);
    chk("t5_first", int'(first_hit), 140);
    chk("t5_last", int'(last_hit), 150);
    chk("t5_valid_cycles", valid_cnt, 44);
    run(130, 140, 2, 0, 0, lat);
    chk("t5_offsample_hits", int'(hit_count), 0);
    chk("t5_offsample_any", int'(any_hit), 0);

    // 6: async reset mid-sweep at code 135
    @(negedge clk);
    mode = 0; code_lo = 8'd120; code_hi = 8'd160; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (code_out != 8'd135 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_reached_135", int'(code_out), 135);
    done_snap = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_code", int'(code_out), 0);
    chk("t6_rst_flags", int'({code_valid, busy, done}), 0);
    chk("t6_rst_results", int'({hit_count, first_hit, last_hit, any_hit}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", done_cnt, done_snap);
    run(128, 154, 0, 0, 0, lat);
    chk("t6_rerun_hits", int'(hit_count), 27);
    chk("t6_rerun_valid", valid_cnt, 108);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/temp_code_sweeper.md
Name: temp_code_sweeper

Overview:
- Sequential stimulus/monitor block that drives the 8-bit switch-code input of the combinational temperature-window detector.
- Steps an 8-bit code from a programmable low bound to a high bound and holds each code for a fixed number of cycles.
- Samples the detector's single-bit LED response at the end of each hold interval and accumulates hit statistics.
- Used on-board and in simulation to characterise the detector's window (expected window is codes 128..154 inclusive).

Parameters:
- HOLD_CYCLES, 4, cycles each code is driven before the response is sampled; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request; only acted on in IDLE.
- code_lo  input  8  first code of the sweep; captured on an accepted start.
- code_hi  input  8  last code of the sweep; captured on an accepted start.
- led_in  input  1  detector response for the code currently on code_out.
- code_out  output  8  code driven to the detector (bit 7 = H ... bit 0 = A).
- code_valid  output  1  high while code_out carries a sweep code.
- busy  output  1  high in the DRIVE state.
- done  output  1  one-cycle pulse when the sweep completes.
- hit_count  output  9  number of swept codes with led_in sampled high (0..256).
- first_hit  output  8  lowest code with a sampled hit.
- last_hit  output  8  highest code with a sampled hit.
- any_hit  output  1  at least one hit recorded in the last sweep.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM to IDLE, hold counter 0, captured bounds 0.
- FSM states: IDLE, DRIVE, FIN.
- IDLE, start=1 at edge t:
  - Capture code_lo/code_hi.
  - Clear hit_count, first_hit, last_hit and any_hit.
  - If code_lo <= code_hi: enter DRIVE; from t+1, code_out=code_lo, code_valid=1, busy=1.
  - If code_lo > code_hi: enter FIN directly; results stay cleared; code_valid is never asserted.
- start while busy or in FIN: ignored; captured bounds do not change.
- DRIVE:
  - Hold counter runs 0..HOLD_CYCLES-1 for each code.
  - On the edge where the counter equals HOLD_CYCLES-1, led_in is sampled for the current code_out.
  - On a sampled hit:
    - hit_count increments.
    - last_hit is set to code_out.
    - If any_hit was 0, first_hit is also set to code_out and any_hit is set to 1.
  - On that same sampling edge:
    - If code_out != captured hi: code_out increments, the counter resets to 0, and the FSM stays in DRIVE.
    - If code_out == captured hi: enter FIN, code_valid drops to 0, busy drops to 0, and code_out holds its last value.
- The end-of-sweep comparison is made before any increment, so hi=255 terminates cleanly with no wrap to 0.
- hit_count is 9 bits, so a full 0..255 sweep of all hits reads 256.
- FIN: done=1 for exactly one cycle, then IDLE. start in the FIN cycle is ignored.
- Results hold until the next accepted start or reset.
- Sweep duration: (hi-lo+1)*HOLD_CYCLES cycles of code_valid; done asserts on the cycle after the last sample.
- led_in is sampled only at the end of the hold interval. This gives the detector and the external path HOLD_CYCLES-1 cycles to settle, and led_in outside the sample cycle is ignored.
- Reset asserted mid-sweep: immediate return to the reset state with code_valid=0. No done pulse; the partial results are discarded.

Test Plan:
1. Reset, then HOLD_CYCLES=4, lo=120, hi=160, bench models the detector (hit iff code in 128..154) -> code_valid high for 164 cycles; done pulses once; hit_count=27, first_hit=128, last_hit=154, any_hit=1.
2. lo=0, hi=255, same detector model -> 1024 valid cycles; code_out never wraps to 0 after 255; done pulses once; hit_count=27.
3. lo=hi=130, led_in tied high -> one code held for 4 cycles; hit_count=1, first_hit=last_hit=130. Then lo=0, hi=255 with led_in tied high -> hit_count=256.
4. lo=200, hi=100 -> done on the cycle after start; code_valid never high; hit_count=0, any_hit=0.
5. Pulse start with lo=10 while a sweep from 140 to 150 is busy -> ignored; the sweep ends at 150 with the unchanged result (11 hits). Then pulse led_in high only at non-sample cycles -> hit_count=0.
6. Drop rst_n asynchronously mid-sweep at code 135 -> all outputs read 0 before the next clk edge; no done pulse; a fresh start afterwards runs normally.
